fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8x8 FIFO. Data width and depth are set by parameters.
//  All 2**ADDR_W entries are usable (extra pointer wrap bit), where the 8x8 FIFO holds only 7.

---
 rtl/fifo_sync_param.sv | 104 ++++++++++
 tb/tb_fifo_sync_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Purpose  : Parametrised single-clock FIFO with occupancy count,
//             almost-full/almost-empty thresholds and overflow/underflow pulses.
//  Options  : define FIFO_FWFT_EN for first-word fall-through read data.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclr,
  input  logic              wren,
  input  logic              rden,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int             c_DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_AF   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] c_AE   = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // The extra pointer bit distinguishes a full ring from an empty one.
  assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_wr_ok = wren && !w_full;
  assign w_rd_ok = rden && !w_empty;

  always_ff @(posedge clk) begin
    if (reset || sclr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wren && w_full;
      r_underflow <= rden && w_empty;
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset so it maps onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (!reset && !sclr && w_wr_ok)
      r_mem[r_wptr[ADDR_W-1:0]] <= din;
  end

`ifdef FIFO_FWFT_EN
  assign dout = r_mem[r_rptr[ADDR_W-1:0]];
`else
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (reset)
      r_dout <= '0;
    else if (!sclr && w_rd_ok)
      r_dout <= r_mem[r_rptr[ADDR_W-1:0]];
  end

  assign dout = r_dout;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= c_AF);
  assign almost_empty = (r_count <= c_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_param
//  Purpose  : Self-checking bench for fifo_sync_param against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int c_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclr = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       wren2 = 1'b0;
  logic [7:0] din2 = '0;
  logic [7:0] dout2;
  logic       full2, empty2, af2, ae2, ovf2, unf2;
  logic [4:0] count2;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) u_dut (
    .clk(clk), .reset(reset), .sclr(sclr), .wren(wren), .rden(rden), .din(din),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(15), .AE_LEVEL(1)) u_dut16 (
    .clk(clk), .reset(reset), .sclr(1'b0), .wren(wren2), .rden(1'b0), .din(din2),
    .dout(dout2), .full(full2), .empty(empty2), .almost_full(af2),
    .almost_empty(ae2), .count(count2), .overflow(ovf2), .underflow(unf2)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == c_DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    if (q.size() != 0) chk("dout_fwft", 32'(dout), 32'(q[0]));
`else
    chk("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  // One clock: drive inputs, advance model by the FIFO's rules, compare after edge.
  task automatic cycle(input logic rst, input logic s, input logic w, input logic r,
                       input logic [7:0] d);
    bit was_full, was_empty;
    reset = rst; sclr = s; wren = w; rden = r; din = d;
    was_full  = (q.size() == c_DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete(); m_dout = '0; m_ovf = 0; m_unf = 0;
    end else if (s) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = w && was_full;
      m_unf = r && was_empty;
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    reset = 0; sclr = 0; wren = 0; rden = 0;
    check_all();
  endtask

  initial begin
    // 1: reset held two cycles
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);

    // 2: fill with 01..08, overflow on 9th, drain in order
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 0, 8'(i));
    cycle(0, 0, 1, 0, 8'hFF);
    cycle(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 8'h00);

    // 3: underflow on empty, then a single word through
    cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'hA5);
    cycle(0, 0, 0, 1, 8'h00);

    // 4: hold at 4 with simultaneous read/write across pointer wrap
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'h00);

    // 5: sclr at 5 beats a simultaneous read/write
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 8'(8'h50 + i));
    cycle(0, 1, 1, 1, 8'hEE);
    cycle(0, 0, 1, 0, 8'h3C);
    cycle(0, 0, 0, 1, 8'h00);

    // 6: reset mid-stream while writing
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 8'(8'h60 + i));
    cycle(1, 0, 1, 0, 8'h77);
    cycle(0, 0, 0, 0, 8'h00);

    // Random traffic with occasional sclr
    for (int i = 0; i < 400; i++) begin
      logic w, r, s;
      w = ($urandom_range(0, 99) < ((i / 50) % 2 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 50) % 2 ? 35 : 70));
      s = ($urandom_range(0, 63) == 0);
      cycle(0, s, w, r, 8'($urandom));
    end

    // Depth-16 instance: full only at 16, almost_full from 15, overflow at 17th
    for (int i = 1; i <= 17; i++) begin
      wren2 = 1; din2 = 8'(i);
      @(posedge clk);
      #1;
      wren2 = 0;
      chk("d16_count", 32'(count2), 32'(i > 16 ? 16 : i));
      chk("d16_full", 32'(full2), 32'(i >= 16));
      chk("d16_almost_full", 32'(af2), 32'(i >= 15));
      chk("d16_overflow", 32'(ovf2), 32'(i == 17));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
